// File: rtl/fp_sched_pkg.sv
// Shared types, op encodings and latency defaults for the FP issue scheduler.
package fp_sched_pkg;

    typedef enum logic [1:0] {
        FP_ADD = 2'd0,
        FP_SUB = 2'd1,
        FP_MUL = 2'd2,
        FP_DIV = 2'd3
    } fp_op_t;

    localparam int REG_W_DEF   = 5;
    localparam int ADD_LAT_DEF = 2;
    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 12;

    typedef logic [REG_W_DEF-1:0] reg_idx_t;

    // Opcodes 4..15 have no FP unit behind them.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Pending-write scoreboard for the FP register file. Reads see the
// writeback of the current cycle already retired (bypass), and a set wins over a clear.
module fp_scoreboard #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en_i,
    input  logic [REG_W-1:0] set_idx_i,
    input  logic             clr_en_i,
    input  logic [REG_W-1:0] clr_idx_i,
    input  logic [REG_W-1:0] rs_idx_i,
    input  logic [REG_W-1:0] rt_idx_i,
    input  logic [REG_W-1:0] rd_idx_i,
    output logic             raw_o,
    output logic             waw_o
);
    localparam int NREG = 2 ** REG_W;

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [NREG-1:0] vis_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;

    // Bypass-masked view, read ports and next pending vector
    always_comb begin
        if (set_en_i) begin
            set_mask_s = {{(NREG-1){1'b0}}, 1'b1} << set_idx_i;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        if (clr_en_i) begin
            clr_mask_s = {{(NREG-1){1'b0}}, 1'b1} << clr_idx_i;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
        vis_s  = pend_q & ~clr_mask_s;
        raw_o  = vis_s[rs_idx_i] | vis_s[rt_idx_i];
        waw_o  = vis_s[rd_idx_i];
        pend_d = vis_s | set_mask_s;
    end

    // Pending vector register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= {NREG{1'b0}};
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/fp_issue_scheduler.sv
// FP issue/writeback scheduler: hazard + result-slot checks, unit start, single writeback port.
// Define FP_SCHED_STATS_EN to add the stat_issued / stat_stall saturating counters.
module fp_issue_scheduler
    import fp_sched_pkg::*;
#(
    parameter int ADD_LAT = ADD_LAT_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int REG_W   = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [3:0]       issue_op,
    input  logic [REG_W-1:0] issue_rd,
    input  logic [REG_W-1:0] issue_rs,
    input  logic [REG_W-1:0] issue_rt,
    input  logic             flush,
    output logic             issue_ready,
    output logic             stall,
    output logic             fu_start,
    output logic [1:0]       fu_sel,
    output logic             div_busy,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    output logic [1:0]       wb_op,
`ifdef FP_SCHED_STATS_EN
    output logic [15:0]      stat_issued,
    output logic [15:0]      stat_stall,
`endif
    output logic             illegal_op
);
    localparam logic [4:0] ADD_L = 5'(ADD_LAT);
    localparam logic [4:0] MUL_L = 5'(MUL_LAT);
    localparam logic [4:0] DIV_L = 5'(DIV_LAT);

    // Slot k holds the op whose writeback is k+1 cycles away.
    logic             res_vld_q [DIV_LAT];
    logic [REG_W-1:0] res_rd_q  [DIV_LAT];
    fp_op_t           res_op_q  [DIV_LAT];
    logic             res_vld_d [DIV_LAT];
    logic [REG_W-1:0] res_rd_d  [DIV_LAT];
    fp_op_t           res_op_d  [DIV_LAT];
    logic             ins_vld_s [DIV_LAT];
    logic [REG_W-1:0] ins_rd_s  [DIV_LAT];
    fp_op_t           ins_op_s  [DIV_LAT];

    logic             div_busy_q, div_busy_d;
    logic             wb_valid_q, wb_valid_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    fp_op_t           wb_op_q, wb_op_d;
    logic             illegal_q, illegal_d;

    fp_op_t     op_s;
    logic       legal_s, is_div_s, cand_s, raw_s, waw_s, slot_free_s, ready_s, accept_s;
    logic [4:0] lat_s, tgt_s;

    fp_scoreboard #(.REG_W(REG_W)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en_i  (accept_s),
        .set_idx_i (issue_rd),
        .clr_en_i  (wb_valid_q),
        .clr_idx_i (wb_rd_q),
        .rs_idx_i  (issue_rs),
        .rt_idx_i  (issue_rt),
        .rd_idx_i  (issue_rd),
        .raw_o     (raw_s),
        .waw_o     (waw_s)
    );

    // Decode, result-slot lookup and the issue decision
    always_comb begin
        op_s     = fp_op_t'(issue_op[1:0]);
        legal_s  = op_is_legal(issue_op);
        is_div_s = legal_s & (op_s == FP_DIV);
        case (op_s)
            FP_ADD, FP_SUB: lat_s = ADD_L;
            FP_MUL:         lat_s = MUL_L;
            FP_DIV:         lat_s = DIV_L;
            default:        lat_s = ADD_L;
        endcase
        tgt_s       = lat_s - 5'd1;
        slot_free_s = 1'b1;
        for (int k = 0; k < DIV_LAT; k++) begin
            if ((5'(k) == tgt_s) && res_vld_q[k]) begin
                slot_free_s = 1'b0;
            end else begin
                slot_free_s = slot_free_s;
            end
        end
        cand_s   = rst_n & issue_valid & ~flush;
        ready_s  = cand_s & (~legal_s |
                   (~raw_s & ~waw_s & slot_free_s & ~(is_div_s & div_busy_q)));
        accept_s = ready_s & legal_s;
    end

    assign issue_ready = ready_s;
    assign stall       = cand_s & ~ready_s;
    assign fu_start    = accept_s;
    assign fu_sel      = accept_s ? issue_op[1:0] : 2'b00;
    assign div_busy    = div_busy_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_op       = wb_op_q;
    assign illegal_op  = illegal_q;

    // Insert the accepted op, then shift: the head goes to the writeback port
    always_comb begin
        for (int k = 0; k < DIV_LAT; k++) begin
            if (accept_s && (5'(k) == tgt_s)) begin
                ins_vld_s[k] = 1'b1;
                ins_rd_s[k]  = issue_rd;
                ins_op_s[k]  = op_s;
            end else begin
                ins_vld_s[k] = res_vld_q[k];
                ins_rd_s[k]  = res_rd_q[k];
                ins_op_s[k]  = res_op_q[k];
            end
        end
        wb_valid_d = ins_vld_s[0];
        wb_rd_d    = ins_rd_s[0];
        wb_op_d    = ins_op_s[0];
        for (int k = 0; k < DIV_LAT - 1; k++) begin
            res_vld_d[k] = ins_vld_s[k+1];
            res_rd_d[k]  = ins_rd_s[k+1];
            res_op_d[k]  = ins_op_s[k+1];
        end
        res_vld_d[DIV_LAT-1] = 1'b0;
        res_rd_d[DIV_LAT-1]  = {REG_W{1'b0}};
        res_op_d[DIV_LAT-1]  = FP_ADD;
        // Busy drops as the divide result lands, freeing the divider that cycle.
        div_busy_d = (div_busy_q | (accept_s & is_div_s)) &
                     ~(ins_vld_s[0] & (ins_op_s[0] == FP_DIV));
        illegal_d  = cand_s & ~legal_s;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DIV_LAT; k++) begin
                res_vld_q[k] <= 1'b0;
                res_rd_q[k]  <= {REG_W{1'b0}};
                res_op_q[k]  <= FP_ADD;
            end
            div_busy_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= {REG_W{1'b0}};
            wb_op_q    <= FP_ADD;
            illegal_q  <= 1'b0;
        end else begin
            for (int k = 0; k < DIV_LAT; k++) begin
                res_vld_q[k] <= res_vld_d[k];
                res_rd_q[k]  <= res_rd_d[k];
                res_op_q[k]  <= res_op_d[k];
            end
            div_busy_q <= div_busy_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_op_q    <= wb_op_d;
            illegal_q  <= illegal_d;
        end
    end

`ifdef FP_SCHED_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d;
    logic [15:0] stat_stall_q, stat_stall_d;

    // Saturating event counters
    always_comb begin
        if (accept_s && (stat_issued_q != 16'hFFFF)) begin
            stat_issued_d = stat_issued_q + 16'd1;
        end else begin
            stat_issued_d = stat_issued_q;
        end
        if (stall && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end else begin
            stat_stall_d = stat_stall_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued_q <= 16'd0;
            stat_stall_q  <= 16'd0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// Self-checking bench for fp_issue_scheduler: in-flight-op queue model plus directed literal checks.
module tb_fp_issue_scheduler;
    localparam int ADD_LAT = 2;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 12;

    logic       clk = 1'b0;
    logic       rst_n, issue_valid, flush;
    logic [3:0] issue_op;
    logic [4:0] issue_rd, issue_rs, issue_rt;
    logic       issue_ready, stall, fu_start, div_busy, wb_valid, illegal_op;
    logic [1:0] fu_sel, wb_op;
    logic [4:0] wb_rd;
`ifdef FP_SCHED_STATS_EN
    logic [15:0] stat_issued, stat_stall;
    int          m_iss = 0, m_stl = 0;
`endif

    always #5 clk = ~clk;

    fp_issue_scheduler #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt), .flush(flush),
        .issue_ready(issue_ready), .stall(stall), .fu_start(fu_start), .fu_sel(fu_sel),
        .div_busy(div_busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_op(wb_op),
`ifdef FP_SCHED_STATS_EN
        .stat_issued(stat_issued), .stat_stall(stat_stall),
`endif
        .illegal_op(illegal_op)
    );

    typedef struct {
        int         acc;
        int         wb;
        logic [4:0] rd;
        logic [1:0] op;
    } rec_t;

    rec_t fl_q[$];
    int   checks = 0, passed = 0, cyc = 0;
    logic armed = 1'b0, prev_ill = 1'b0;
    logic o_ready, o_stall, o_start, o_busy, o_wbv, o_ill;
    logic [1:0] o_sel, o_wbop;
    logic [4:0] o_wbrd;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    endtask

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'd2:    return MUL_LAT;
            2'd3:    return DIV_LAT;
            default: return ADD_LAT;
        endcase
    endfunction

    // Register r still awaits a result that lands after this cycle.
    function automatic logic pend(input logic [4:0] r);
        foreach (fl_q[i]) if (fl_q[i].rd == r && fl_q[i].wb > cyc) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive, compare every output against the model, advance the model.
    task automatic step(input logic v, input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic fl,
                        input logic rn);
        logic       e_wbv, e_busy, legal, cand, e_ready;
        logic [4:0] e_wbrd;
        logic [1:0] e_wbop;
        int         L;
        @(negedge clk);
        rst_n = rn; issue_valid = v; issue_op = op; issue_rd = rd;
        issue_rs = rs; issue_rt = rt; flush = fl;
        #1;
        e_wbv = 1'b0; e_wbrd = 5'd0; e_wbop = 2'd0; e_busy = 1'b0;
        foreach (fl_q[i]) begin
            if (fl_q[i].wb == cyc) begin
                e_wbv = 1'b1; e_wbrd = fl_q[i].rd; e_wbop = fl_q[i].op;
            end
            if (fl_q[i].op == 2'd3 && fl_q[i].acc < cyc && fl_q[i].wb > cyc) e_busy = 1'b1;
        end
        legal   = (op < 4'd4);
        L       = lat_of(op[1:0]);
        cand    = v & ~fl & rn;
        e_ready = cand;
        if (cand && legal) begin
            if (pend(rs) || pend(rt) || pend(rd)) e_ready = 1'b0;
            foreach (fl_q[i]) if (fl_q[i].wb == cyc + L) e_ready = 1'b0;
            if (op[1:0] == 2'd3 && e_busy) e_ready = 1'b0;
        end
        o_ready = issue_ready; o_stall = stall; o_start = fu_start; o_sel = fu_sel;
        o_busy = div_busy; o_wbv = wb_valid; o_wbrd = wb_rd; o_wbop = wb_op; o_ill = illegal_op;
        if (armed) begin
            chk("issue_ready", o_ready, e_ready);
            chk("stall", o_stall, cand & ~e_ready);
            chk("fu_start", o_start, e_ready & legal);
            chk("fu_sel", o_sel, (e_ready & legal) ? op[1:0] : 2'd0);
            chk("div_busy", o_busy, e_busy);
            chk("wb_valid", o_wbv, e_wbv);
            if (e_wbv) begin
                chk("wb_rd", o_wbrd, e_wbrd);
                chk("wb_op", o_wbop, e_wbop);
            end
            chk("illegal_op", o_ill, prev_ill);
`ifdef FP_SCHED_STATS_EN
            chk("stat_issued", stat_issued, m_iss);
            chk("stat_stall", stat_stall, m_stl);
`endif
        end
        if (!rn) begin
            fl_q.delete();
            prev_ill = 1'b0;
            armed    = 1'b1;
`ifdef FP_SCHED_STATS_EN
            m_iss = 0; m_stl = 0;
`endif
        end else begin
            for (int i = fl_q.size() - 1; i >= 0; i--) if (fl_q[i].wb <= cyc) fl_q.delete(i);
            if (e_ready && legal) fl_q.push_back('{acc: cyc, wb: cyc + L, rd: rd, op: op[1:0]});
            prev_ill = cand & ~legal;
`ifdef FP_SCHED_STATS_EN
            if (e_ready && legal && m_iss < 65535) m_iss++;
            if (cand && !e_ready && m_stl < 65535) m_stl++;
`endif
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic       v, fl, rn, last_stall;
        logic [3:0] op;
        logic [4:0] rd, rs, rt;

        step(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        idle();
        chk("rst_wb_valid", o_wbv, 1'b0);
        chk("rst_div_busy", o_busy, 1'b0);
        chk("rst_illegal", o_ill, 1'b0);

        // add rd=3: start, writeback two cycles later, then rd=3 readable
        step(1'b1, 4'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("t1_ready", o_ready, 1'b1);
        chk("t1_start", o_start, 1'b1);
        chk("t1_sel", o_sel, 2'd0);
        idle(); idle();
        chk("t1_wbv", o_wbv, 1'b1);
        chk("t1_wbrd", o_wbrd, 5'd3);
        chk("t1_wbop", o_wbop, 2'd0);
        step(1'b1, 4'd0, 5'd9, 5'd3, 5'd3, 1'b0, 1'b1);
        chk("t1_pend_clear", o_ready, 1'b1);
        drain(4);

        // RAW on a mul result, released by the writeback bypass
        step(1'b1, 4'd2, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("t2_sel", o_sel, 2'd2);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 4'd0, 5'd5, 5'd4, 5'd0, 1'b0, 1'b1);
            chk("t2_stall", o_stall, 1'b1);
        end
        step(1'b1, 4'd0, 5'd5, 5'd4, 5'd0, 1'b0, 1'b1);
        chk("t2_bypass_ready", o_ready, 1'b1);
        chk("t2_wbrd4", o_wbrd, 5'd4);
        idle(); idle();
        chk("t2_wbv5", o_wbv, 1'b1);
        chk("t2_wbrd5", o_wbrd, 5'd5);
        drain(4);

        // result-bus slot conflict between mul and a later add
        step(1'b1, 4'd2, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
        idle();
        step(1'b1, 4'd0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("t3_slot_stall", o_stall, 1'b1);
        step(1'b1, 4'd0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("t3_ready", o_ready, 1'b1);
        idle();
        chk("t3_wbrd1", o_wbrd, 5'd1);
        idle();
        chk("t3_wbv2", o_wbv, 1'b1);
        chk("t3_wbrd2", o_wbrd, 5'd2);
        drain(4);

        // back-to-back divides serialise on the divider
        step(1'b1, 4'd3, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 11; i++) begin
            step(1'b1, 4'd3, 5'd8, 5'd0, 5'd0, 1'b0, 1'b1);
            chk("t4_stall", o_stall, 1'b1);
            chk("t4_busy", o_busy, 1'b1);
        end
        step(1'b1, 4'd3, 5'd8, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("t4_ready", o_ready, 1'b1);
        chk("t4_wbrd7", o_wbrd, 5'd7);
        chk("t4_wbop", o_wbop, 2'd3);
        chk("t4_busy_clear", o_busy, 1'b0);
        drain(12);
        chk("t4_wbv8", o_wbv, 1'b1);
        chk("t4_wbrd8", o_wbrd, 5'd8);
        drain(3);

        // illegal opcode
        step(1'b1, 4'd9, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("t5_ready", o_ready, 1'b1);
        chk("t5_start", o_start, 1'b0);
        idle();
        chk("t5_illegal", o_ill, 1'b1);
        idle();
        chk("t5_illegal_pulse", o_ill, 1'b0);
        drain(3);

        // reset drops an in-flight divide
        step(1'b1, 4'd3, 5'd10, 5'd0, 5'd0, 1'b0, 1'b1);
        drain(4);
        step(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        idle();
        chk("t6_busy", o_busy, 1'b0);
        chk("t6_wbv", o_wbv, 1'b0);
        step(1'b1, 4'd0, 5'd10, 5'd10, 5'd10, 1'b0, 1'b1);
        chk("t6_pend_cleared", o_ready, 1'b1);
        drain(5);
        chk("t6_no_wb", o_wbv, 1'b0);
        drain(3);

        // randomized traffic; a stalled instruction is usually held
        last_stall = 1'b0;
        v = 1'b0; op = 4'd0; rd = 5'd0; rs = 5'd0; rt = 5'd0;
        for (int n = 0; n < 3000; n++) begin
            if (!(last_stall && $urandom_range(0, 9) < 7)) begin
                v  = ($urandom_range(0, 9) < 7);
                op = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(4, 15))
                                                   : 4'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 7));
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
            end
            fl = ($urandom_range(0, 19) == 0);
            rn = ($urandom_range(0, 199) != 0);
            step(v, op, rd, rs, rt, fl, rn);
            last_stall = o_stall;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
